// File: rtl/gpio_in_cond_if.sv
// ic0 bus bundle between a master and the gpio_in_cond slave.
// Writes complete on any clk edge with wr_valid=1. A read is accepted in the
// cycle where rd_valid=1 and rd_ready_2=1; rd_data_2 is valid only then.
interface gpio_in_cond_if;
  logic        ic0_c_axi_mst_wr_valid;
  logic [31:0] ic0_axi_mst_wr_addr;
  logic [31:0] ic0_axi_mst_wr_data;
  logic        ic0_c_axi_mst_rd_valid;
  logic [31:0] ic0_axi_mst_rd_addr;
  logic        ic0_c_axi_slv_rd_ready_2;
  logic [31:0] ic0_axi_slv_rd_data_2;

  modport master (
    output ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data,
    output ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
    input  ic0_c_axi_slv_rd_ready_2, ic0_axi_slv_rd_data_2
  );

  modport slave (
    input  ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data,
    input  ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
    output ic0_c_axi_slv_rd_ready_2, ic0_axi_slv_rd_data_2
  );
endinterface

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioner: 2-flop sync, counter debounce, edge detect
// with latched W1C interrupt status, configured over the ic0 bus.
module gpio_in_cond #(
  parameter logic [31:0]      BASE    = 32'h80030000,
  parameter logic [31:0]      OFFSET  = 32'h00000200,
  parameter int               BW      = 8,
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] DEB_RST = '0
) (
  input  logic          clk,
  input  logic          c_sys_rst,
  input  logic [BW-1:0] pin_in,
  output logic [BW-1:0] pin_clean,
  output logic          irq,
  gpio_in_cond_if.slave ic0
);

  localparam logic [31:0] A_DEB   = BASE + OFFSET;
  localparam logic [31:0] A_RISE  = BASE + OFFSET + 32'h04;
  localparam logic [31:0] A_FALL  = BASE + OFFSET + 32'h08;
  localparam logic [31:0] A_STAT  = BASE + OFFSET + 32'h0C;
  localparam logic [31:0] A_CLEAN = BASE + OFFSET + 32'h10;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [BW-1:0]    s1, s2;
  logic [CNT_W-1:0] cnt     [BW];
  logic [CNT_W-1:0] cnt_nxt [BW];
  logic [CNT_W-1:0] debounce;
  logic [BW-1:0]    rise_en, fall_en, irq_status;
  logic [BW-1:0]    next_clean, rise, fall, clr;
  logic             wr_deb, wr_rise, wr_fall, wr_stat;
  logic             rd_ready;
  logic [31:0]      rd_data;

  assign wr_deb  = ic0.ic0_c_axi_mst_wr_valid && (ic0.ic0_axi_mst_wr_addr == A_DEB);
  assign wr_rise = ic0.ic0_c_axi_mst_wr_valid && (ic0.ic0_axi_mst_wr_addr == A_RISE);
  assign wr_fall = ic0.ic0_c_axi_mst_wr_valid && (ic0.ic0_axi_mst_wr_addr == A_FALL);
  assign wr_stat = ic0.ic0_c_axi_mst_wr_valid && (ic0.ic0_axi_mst_wr_addr == A_STAT);

  // The >= compare lets a lowered threshold take effect at once; the counter
  // only increments while below the threshold, so it can never wrap.
  always_comb begin
    next_clean = pin_clean;
    cnt_nxt    = '{default: '0};
    for (int i = 0; i < BW; i++) begin
      if (s2[i] != pin_clean[i]) begin
        if (cnt[i] >= debounce) next_clean[i] = s2[i];
        else                    cnt_nxt[i]    = cnt[i] + CNT_ONE;
      end
    end
  end

  assign rise = rise_en & ~pin_clean &  next_clean;
  assign fall = fall_en &  pin_clean & ~next_clean;
  assign clr  = wr_stat ? ic0.ic0_axi_mst_wr_data[BW-1:0] : '0;
  assign irq  = |irq_status;

  always_ff @(posedge clk or posedge c_sys_rst) begin
    if (c_sys_rst) begin
      s1         <= '0;
      s2         <= '0;
      pin_clean  <= '0;
      for (int i = 0; i < BW; i++) cnt[i] <= '0;
      debounce   <= DEB_RST;
      rise_en    <= '0;
      fall_en    <= '0;
      irq_status <= '0;
    end else begin
      s1         <= pin_in;
      s2         <= s1;
      pin_clean  <= next_clean;
      for (int i = 0; i < BW; i++) cnt[i] <= cnt_nxt[i];
      if (wr_deb)  debounce <= ic0.ic0_axi_mst_wr_data[CNT_W-1:0];
      if (wr_rise) rise_en  <= ic0.ic0_axi_mst_wr_data[BW-1:0];
      if (wr_fall) fall_en  <= ic0.ic0_axi_mst_wr_data[BW-1:0];
      // New events are ORed in after the clear, so a same-cycle set wins.
      irq_status <= (irq_status & ~clr) | rise | fall;
    end
  end

  always_comb begin
    rd_ready = 1'b0;
    rd_data  = 'x;
    if (ic0.ic0_c_axi_mst_rd_valid) begin
      case (ic0.ic0_axi_mst_rd_addr)
        A_DEB:   begin rd_ready = 1'b1; rd_data = 32'(debounce);   end
        A_RISE:  begin rd_ready = 1'b1; rd_data = 32'(rise_en);    end
        A_FALL:  begin rd_ready = 1'b1; rd_data = 32'(fall_en);    end
        A_STAT:  begin rd_ready = 1'b1; rd_data = 32'(irq_status); end
        A_CLEAN: begin rd_ready = 1'b1; rd_data = 32'(pin_clean);  end
        default: ;
      endcase
    end
  end

  assign ic0.ic0_c_axi_slv_rd_ready_2 = rd_ready;
  assign ic0.ic0_axi_slv_rd_data_2    = rd_data;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed and randomized bench for gpio_in_cond against a streak-based
// behavioural model of synchroniser, debounce and interrupt status.
module tb_gpio_in_cond;

  localparam logic [31:0] A = 32'h80030200;

  logic       clk;
  logic       c_sys_rst;
  logic [7:0] pin_in;
  logic [7:0] pin_clean;
  logic       irq;
  int         n_tests;
  int         n_fail;

  gpio_in_cond_if bus ();

  gpio_in_cond dut (
    .clk       (clk),
    .c_sys_rst (c_sys_rst),
    .pin_in    (pin_in),
    .pin_clean (pin_clean),
    .irq       (irq),
    .ic0       (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A pin's clean level follows s2 once s2 has disagreed with it for more
  // than DEBOUNCE consecutive edges; s2 is the pad value from two edges ago.
  logic [7:0]  m_clean, m_rise, m_fall, m_stat;
  logic [15:0] m_deb;
  int          m_streak [8];
  logic [7:0]  pin_hist [$];

  always @(posedge clk or posedge c_sys_rst) begin
    logic [7:0] s2v, nclean, ev, clrv;
    if (c_sys_rst) begin
      m_clean = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_deb = 16'd0;
      for (int i = 0; i < 8; i++) m_streak[i] = 0;
      pin_hist = {8'h00, 8'h00};
    end else begin
      s2v    = pin_hist[0];
      nclean = m_clean;
      for (int i = 0; i < 8; i++) begin
        if (s2v[i] != m_clean[i]) begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] > int'(m_deb)) begin
            nclean[i]   = s2v[i];
            m_streak[i] = 0;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      ev   = (m_rise & ~m_clean & nclean) | (m_fall & m_clean & ~nclean);
      clrv = (bus.ic0_c_axi_mst_wr_valid && bus.ic0_axi_mst_wr_addr == A + 32'h0C)
             ? bus.ic0_axi_mst_wr_data[7:0] : 8'h00;
      m_stat = (m_stat & ~clrv) | ev;
      if (bus.ic0_c_axi_mst_wr_valid) begin
        if (bus.ic0_axi_mst_wr_addr == A)         m_deb  = bus.ic0_axi_mst_wr_data[15:0];
        if (bus.ic0_axi_mst_wr_addr == A + 32'h4) m_rise = bus.ic0_axi_mst_wr_data[7:0];
        if (bus.ic0_axi_mst_wr_addr == A + 32'h8) m_fall = bus.ic0_axi_mst_wr_data[7:0];
      end
      m_clean = nclean;
      void'(pin_hist.pop_front());
      pin_hist.push_back(pin_in);
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_clean"}, 32'(pin_clean), 32'(m_clean));
    chk({tag, "_irq"},   32'(irq),       32'(|m_stat));
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
    bus.ic0_c_axi_mst_wr_valid = 1'b1;
    bus.ic0_axi_mst_wr_addr    = A + 32'(off);
    bus.ic0_axi_mst_wr_data    = data;
    @(negedge clk);
    bus.ic0_c_axi_mst_wr_valid = 1'b0;
    bus.ic0_axi_mst_wr_addr    = '0;
    bus.ic0_axi_mst_wr_data    = '0;
  endtask

  task automatic bus_read(input logic [7:0] off, input logic exp_rdy,
                          input logic [31:0] exp_data, input string tag);
    bus.ic0_c_axi_mst_rd_valid = 1'b1;
    bus.ic0_axi_mst_rd_addr    = A + 32'(off);
    #1;
    chk({tag, "_rdy"}, 32'(bus.ic0_c_axi_slv_rd_ready_2), 32'(exp_rdy));
    if (exp_rdy) chk({tag, "_data"}, bus.ic0_axi_slv_rd_data_2, exp_data);
    bus.ic0_c_axi_mst_rd_valid = 1'b0;
    bus.ic0_axi_mst_rd_addr    = '0;
  endtask

  task automatic cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_model(tag);
    end
  endtask

  task automatic random_phase(input int n);
    logic [7:0] mask;
    bus_write(8'h00, 32'($urandom_range(0, 5)));
    bus_write(8'h04, 32'($urandom_range(0, 255)));
    bus_write(8'h08, 32'($urandom_range(0, 255)));
    for (int k = 0; k < n; k++) begin
      mask   = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      pin_in = pin_in ^ mask;
      if ($urandom_range(0, 15) == 0) begin
        bus_write(8'h0C, 32'($urandom_range(0, 255)));
      end else begin
        @(negedge clk);
      end
      chk_model("rnd");
      if (k % 16 == 0) bus_read(8'h0C, 1'b1, 32'(m_stat), "rnd_stat");
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.ic0_c_axi_mst_wr_valid = 1'b0;
    bus.ic0_axi_mst_wr_addr    = '0;
    bus.ic0_axi_mst_wr_data    = '0;
    bus.ic0_c_axi_mst_rd_valid = 1'b0;
    bus.ic0_axi_mst_rd_addr    = '0;
    pin_in    = 8'hFF;
    c_sys_rst = 1'b1;

    // 1: reset with pins high, clean level appears on the 3rd edge after release
    repeat (3) @(negedge clk);
    chk("rst_clean", 32'(pin_clean), 32'h00);
    chk("rst_irq",   32'(irq),       32'h0);
    bus_read(8'h0C, 1'b1, 32'h0, "rst_stat");
    bus_read(8'h00, 1'b1, 32'h0, "rst_deb");
    c_sys_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rel_e2_clean", 32'(pin_clean), 32'h00);
    @(negedge clk);
    chk("rel_e3_clean", 32'(pin_clean), 32'hFF);
    chk_model("rel");
    bus_read(8'h0C, 1'b1, 32'h0, "rel_stat");

    // 2: DEBOUNCE=4, 4-cycle glitch rejected, held level passes after 7 edges
    pin_in = 8'h00;
    cycles(5, "t2_settle");
    bus_write(8'h00, 32'd4);
    pin_in = 8'h01;
    cycles(4, "t2_glitch");
    pin_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_glitch_rej", 32'(pin_clean[0]), 32'h0);
    end
    pin_in = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t2_hold_lo", 32'(pin_clean[0]), 32'h0);
    end
    @(negedge clk);
    chk("t2_edge7", 32'(pin_clean[0]), 32'h1);
    chk_model("t2");

    // 3: enables, rise on pin0 and fall on pin1 latch status
    bus_write(8'h00, 32'd0);
    bus_write(8'h04, 32'h01);
    bus_write(8'h08, 32'h02);
    pin_in = 8'h00; cycles(4, "t3a");
    pin_in = 8'h01; cycles(4, "t3b");
    pin_in = 8'h03; cycles(4, "t3c");
    pin_in = 8'h01; cycles(4, "t3d");
    chk("t3_irq", 32'(irq), 32'h1);
    bus_read(8'h0C, 1'b1, 32'h3, "t3_stat");

    // 4: clear coinciding with a new pin0 rise keeps bit0; full clear empties
    pin_in = 8'h00; cycles(4, "t4a");
    pin_in = 8'h01;
    @(negedge clk);
    @(negedge clk);
    bus_write(8'h0C, 32'h01);
    bus_read(8'h0C, 1'b1, 32'h3, "t4_setwins");
    chk_model("t4b");
    bus_write(8'h0C, 32'h03);
    bus_read(8'h0C, 1'b1, 32'h0, "t4_clr");
    chk("t4_irq", 32'(irq), 32'h0);

    // 5: lowering DEBOUNCE mid-count applies on the next edge
    bus_write(8'h00, 32'd100);
    pin_in = 8'h00;
    repeat (52) @(negedge clk);
    chk("t5_before", 32'(pin_clean[0]), 32'h1);
    bus_write(8'h00, 32'd10);
    chk("t5_wr_edge", 32'(pin_clean[0]), 32'h1);
    @(negedge clk);
    chk("t5_next", 32'(pin_clean[0]), 32'h0);
    chk_model("t5");

    // 6: unmapped read refused, CLEAN write ignored
    bus_read(8'h14, 1'b0, 32'h0, "t6_unmapped");
    bus_write(8'h10, 32'hFF);
    bus_write(8'h14, 32'hFFFF);
    bus_read(8'h10, 1'b1, 32'(m_clean), "t6_clean");
    bus_read(8'h00, 1'b1, 32'd10,       "t6_deb");
    bus_read(8'h04, 1'b1, 32'h01,       "t6_rise");
    bus_read(8'h08, 1'b1, 32'h02,       "t6_fall");
    bus_read(8'h0C, 1'b1, 32'(m_stat),  "t6_stat");

    // randomized traffic against the model
    for (int r = 0; r < 4; r++) random_phase(200);

    // asynchronous reset mid-debounce
    bus_write(8'h00, 32'd6);
    pin_in = 8'hA5;
    cycles(12, "mr_settle");
    pin_in = 8'h5A;
    repeat (5) @(negedge clk);
    c_sys_rst = 1'b1;
    #1;
    chk("mr_clean", 32'(pin_clean), 32'h00);
    chk("mr_irq",   32'(irq),       32'h0);
    bus_read(8'h00, 1'b1, 32'h0, "mr_deb");
    bus_read(8'h04, 1'b1, 32'h0, "mr_rise");
    @(negedge clk);
    c_sys_rst = 1'b0;
    cycles(6, "mr_post");
    random_phase(150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
